seeded_lane_scrambler: RTL and testbench
========================================

// Module: seeded_lane_scrambler
// PURPOSE
//  Parametrised multi-lane keystream scrambler for packed-array datapaths; successor to the fixed not/xor gate cells.
//  Each beat is XORed with a seeded xorshift64/Weyl keystream, optionally inverted, and output after one register stage.
//  Seed pairs use the "a,b" form of the generator seeds.
//  Sits between a packed-array producer and consumer; valid/ready on both sides; reseedable at run time.
// PARAMETERS
//  LANES   4                      number of packed lanes per beat
//  W       8                      bits per lane; LANES*W <= 64 (elaboration error otherwise)
//  CNT_W   32                     width of accepted-beat counter
// PORTS
//  clk          in   1            single clock, rising edge
//  rst_n        in   1            asynchronous, active-low reset
//  seed_valid   in   1            seed pair offered
//  seed_ready   out  1            seed pair accepted when seed_valid && seed_ready
//  seed_a       in   64           xorshift state seed
//  seed_b       in   64           Weyl counter seed
//  invert_mode  in   1            0: out = in ^ key; 1: out = ~(in ^ key); sampled on input accept
//  in_valid     in   1            input beat offered
//  in_ready     out  1            input beat accepted when in_valid && in_ready
//  in_data      in   [LANES][W]   packed input beat, lane 0 = LSBs
//  out_valid    out  1            output register holds a beat
//  out_ready    in   1            consumer accepts output
//  out_data     out  [LANES][W]   scrambled beat
//  beats        out  CNT_W        input beats accepted since last seed load
// BEHAVIOUR
//  - Reset (async assert, sync release): state UNSEEDED, s_a=64'h1, s_b=0, out_valid=0, out_data=0, beats=0.
//  - FSM: UNSEEDED --seed accept--> RUN; RUN --seed accept--> RUN (reseed). No other transitions; reset from any state.
//  - seed_ready = !out_valid. On accept: s_a = (seed_a==0) ? 64'h1 : seed_a; s_b = seed_b; beats = 0.
//  - in_ready = (state==RUN) && !seed_valid && (!out_valid || out_ready). Seed has priority in the same cycle.
//  - key = s_a ^ s_b (current, pre-advance); lane k key = key[(k*W)+:W].
//  - On input accept: out_data <= in ^ key (inverted if invert_mode), out_valid <= 1; then advance:
//    s_a <= xs(s_a): x^=x<<13; x^=x>>7; x^=x<<17 (64-bit, truncating); s_b <= s_b + 64'h9E3779B97F4A7C15 (mod 2^64);
//    beats <= beats+1, wraps to 0 after all-ones.
//  - Latency: 1 cycle in-accept to out_valid. Full throughput (1 beat/cycle) while out_ready=1.
//  - out_valid && !out_ready: out_data, s_a, s_b and beats hold; in_ready=0. Drain with no new input: out_valid <= 0.
//  - In UNSEEDED, in_ready=0 and no keystream advance.
//  - Reset mid-beat: pending output dropped; state returns to UNSEEDED; reseed is required.
// STRUCTURE
//  - scrambler_pkg: XS_SHL1=13, XS_SHR=7, XS_SHL2=17, WEYL_INC=64'h9E3779B97F4A7C15, SEED_ZERO_SUB=64'h1,
//    typedef enum logic {UNSEEDED, RUN} scr_state_e.
//  - Sub-module xorshift64_step: combinational 64-bit next-state function; instantiated once.
//  - Top: FSM, seed/keystream registers, lane XOR/invert, output register, counter.
// TESTING (LANES=4, W=8)
//  - Reset; in_valid=1 without seed -> in_ready=0, out_valid stays 0, beats=0.
//  - Seed a=1,b=0; two zero beats, mode 0 -> out 0x00000001, then 0x3FC85C54; beats=2.
//  - Seed a=0,b=0 -> identical to a=1,b=0 (zero substitution); first zero beat -> 0x00000001.
//  - Seed a=1,b=0; mode 1; in=0xFFFFFFFF -> out=0x00000001.
//  - After out_valid=1, hold out_ready=0 for 5 cycles -> out_data stable; in_ready=0; next beat key unchanged.
//  - Same-cycle seed_valid and in_valid with out empty -> seed taken, input stalled; drop rst_n mid-stream -> all outputs 0, UNSEEDED.

Source files
------------

// File: rtl/scrambler_pkg.sv
// rtl/scrambler_pkg.sv - shared constants and state type for the seeded lane scrambler
package scrambler_pkg;

    // xorshift64 shift amounts
    localparam int XS_SHL1 = 13;
    localparam int XS_SHR  = 7;
    localparam int XS_SHL2 = 17;

    // Weyl sequence increment (golden-ratio constant)
    localparam logic [63:0] WEYL_INC      = 64'h9E3779B97F4A7C15;
    // xorshift has an all-zero fixed point, so a zero seed is replaced by this
    localparam logic [63:0] SEED_ZERO_SUB = 64'h1;

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } scr_state_e;

endpackage

// File: rtl/xorshift64_step.sv
// rtl/xorshift64_step.sv - combinational xorshift64 next-state function
//
// Ports:
//   x  in   64  current generator state
//   y  out  64  next generator state (x^=x<<13; x^=x>>7; x^=x<<17)
module xorshift64_step
    import scrambler_pkg::*;
(
    input  logic [63:0] x,
    output logic [63:0] y
);

    logic [63:0] t1;
    logic [63:0] t2;

    assign t1 = x  ^ (x  << XS_SHL1);
    assign t2 = t1 ^ (t1 >> XS_SHR);
    assign y  = t2 ^ (t2 << XS_SHL2);

endmodule

// File: rtl/seeded_lane_scrambler.sv
// rtl/seeded_lane_scrambler.sv - multi-lane xorshift64/Weyl keystream scrambler with one output register
//
// Ports:
//   clk          in   1             rising-edge clock
//   rst_n        in   1             asynchronous active-low reset
//   seed_valid   in   1             seed pair offered
//   seed_ready   out  1             seed pair taken when seed_valid && seed_ready
//   seed_a       in   64            xorshift state seed (zero is replaced by 1)
//   seed_b       in   64            Weyl counter seed
//   invert_mode  in   1             0: out = in ^ key, 1: out = ~(in ^ key)
//   in_valid     in   1             input beat offered
//   in_ready     out  1             input beat taken when in_valid && in_ready
//   in_data      in   [LANES][W]    input beat, lane 0 in the LSBs
//   out_valid    out  1             output register holds a beat
//   out_ready    in   1             consumer accepts the output beat
//   out_data     out  [LANES][W]    scrambled beat
//   beats        out  CNT_W         input beats accepted since the last seed load
module seeded_lane_scrambler
    import scrambler_pkg::*;
#(
    parameter int LANES = 4,
    parameter int W     = 8,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      seed_valid,
    output logic                      seed_ready,
    input  logic [63:0]               seed_a,
    input  logic [63:0]               seed_b,
    input  logic                      invert_mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0][W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0][W-1:0]   out_data,
    output logic [CNT_W-1:0]          beats
);

    localparam int DW = LANES * W;

    generate
        if (DW > 64) begin : g_width_check
            $error("seeded_lane_scrambler: LANES*W must not exceed 64");
        end
    endgenerate

    scr_state_e  state_q;
    scr_state_e  state_d;
    logic [63:0] s_a;
    logic [63:0] s_b;
    logic [63:0] s_a_next;
    logic [DW-1:0] key;
    logic [DW-1:0] mixed;
    logic          seed_accept;
    logic          in_accept;

    xorshift64_step u_xs (
        .x (s_a),
        .y (s_a_next)
    );

    // A seed can only land while the output register is empty, so a reseed
    // never changes the key behind a beat that is still waiting to leave.
    assign seed_ready  = !out_valid;
    assign seed_accept = seed_valid && seed_ready;

    // Holding off input whenever a seed is offered gives the seed priority
    // in the same cycle and keeps the two updates of s_a/s_b exclusive.
    assign in_ready  = (state_q == RUN) && !seed_valid && (!out_valid || out_ready);
    assign in_accept = in_valid && in_ready;

    // Key for the current beat is taken before the generator advances.
    assign key   = s_a[DW-1:0] ^ s_b[DW-1:0];
    assign mixed = in_data ^ key;

    always_comb begin
        state_d = state_q;
        if (seed_accept) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNSEEDED;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_a   <= SEED_ZERO_SUB;
            s_b   <= '0;
            beats <= '0;
        end else if (seed_accept) begin
            s_a   <= (seed_a == 64'h0) ? SEED_ZERO_SUB : seed_a;
            s_b   <= seed_b;
            beats <= '0;
        end else if (in_accept) begin
            s_a   <= s_a_next;
            s_b   <= s_b + WEYL_INC;
            beats <= beats + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_accept) begin
            out_valid <= 1'b1;
            out_data  <= invert_mode ? ~mixed : mixed;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seeded_lane_scrambler.sv
// tb/tb_seeded_lane_scrambler.sv - directed self-checking bench for seeded_lane_scrambler
module tb_seeded_lane_scrambler;

    logic        clk;
    logic        rst_n;
    logic        seed_valid;
    logic        seed_ready;
    logic [63:0] seed_a;
    logic [63:0] seed_b;
    logic        invert_mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] beats;

    int vectors = 0;
    int miscompares = 0;

    seeded_lane_scrambler #(
        .LANES (4),
        .W     (8),
        .CNT_W (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seed_valid  (seed_valid),
        .seed_ready  (seed_ready),
        .seed_a      (seed_a),
        .seed_b      (seed_b),
        .invert_mode (invert_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .beats       (beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_seed(input logic [63:0] a, input logic [63:0] b);
        seed_valid = 1'b1;
        seed_a     = a;
        seed_b     = b;
        tick();
        seed_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        seed_valid  = 1'b0;
        seed_a      = '0;
        seed_b      = '0;
        invert_mode = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        tick();
        tick();

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_beats", 64'(beats), 64'd0);
        chk("rst_seed_ready", 64'(seed_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // input offered before any seed: blocked
        in_valid = 1'b1;
        in_data  = 32'h0;
        #1;
        chk("unseeded_in_ready", 64'(in_ready), 64'd0);
        tick(); tick(); tick();
        chk("unseeded_out_valid", 64'(out_valid), 64'd0);
        chk("unseeded_beats", 64'(beats), 64'd0);
        in_valid = 1'b0;

        // a=1,b=0: keys 0x00000001 then 0x3FC85C54
        load_seed(64'h1, 64'h0);
        in_valid = 1'b1;
        in_data  = 32'h0;
        #1;
        chk("run_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("b0_out_valid", 64'(out_valid), 64'd1);
        chk("b0_out_data", 64'(out_data), 64'h00000001);
        chk("b0_beats", 64'(beats), 64'd1);
        tick();
        chk("b1_out_data", 64'(out_data), 64'h3FC85C54);
        chk("b1_beats", 64'(beats), 64'd2);
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_beats", 64'(beats), 64'd2);

        // zero seed substitutes to a=1
        load_seed(64'h0, 64'h0);
        chk("reseed_beats", 64'(beats), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'h0;
        tick();
        chk("zseed_out_data", 64'(out_data), 64'h00000001);
        chk("zseed_beats", 64'(beats), 64'd1);
        in_valid = 1'b0;
        tick();

        // invert mode, then plain mode with nonzero data
        load_seed(64'h1, 64'h0);
        in_valid    = 1'b1;
        invert_mode = 1'b1;
        in_data     = 32'hFFFFFFFF;
        tick();
        chk("inv_out_data", 64'(out_data), 64'h00000001);
        invert_mode = 1'b0;
        in_data     = 32'h12345678;
        tick();
        chk("plain_out_data", 64'(out_data), 64'h2DFC0A2C);
        in_valid = 1'b0;
        tick();

        // backpressure: output and keystream hold while out_ready=0
        load_seed(64'h1, 64'h0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0;
        tick();
        chk("stall_first_out", 64'(out_data), 64'h00000001);
        in_data = 32'hAAAAAAAA;
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_data", 64'(out_data), 64'h00000001);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_seed_ready", 64'(seed_ready), 64'd0);
            chk("stall_beats", 64'(beats), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        in_data   = 32'h0;
        #1;
        chk("unstall_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("unstall_out_data", 64'(out_data), 64'h3FC85C54);
        chk("unstall_beats", 64'(beats), 64'd2);
        in_valid = 1'b0;
        tick();

        // seed and input in the same cycle: seed wins, input waits
        seed_valid = 1'b1;
        seed_a     = 64'h1;
        seed_b     = 64'h5;
        in_valid   = 1'b1;
        in_data    = 32'h0;
        #1;
        chk("prio_seed_ready", 64'(seed_ready), 64'd1);
        chk("prio_in_ready", 64'(in_ready), 64'd0);
        tick();
        seed_valid = 1'b0;
        chk("prio_out_valid", 64'(out_valid), 64'd0);
        chk("prio_beats", 64'(beats), 64'd0);
        tick();
        chk("prio_out_data", 64'(out_data), 64'h00000004);
        chk("prio_beats1", 64'(beats), 64'd1);

        // asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_out_data", 64'(out_data), 64'd0);
        chk("areset_beats", 64'(beats), 64'd0);
        chk("areset_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("post_reset_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
